// File: rtl/exe_stage_mc.sv
// exe_stage_mc: execute stage of the 5-stage ARM pipeline.
// Operand forwarding, Val2 generation (rotated immediate / shifted register /
// load-store offset), ALU with NZCV flags, branch-target adder and the EXE/MEM
// output register. When the EXE_MUL_EN macro is defined, an iterative
// shift-add multiplier (exe_cmd 10) is added, with a busy stall to upstream.
module exe_stage_mc #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              in_valid,
  input  logic [3:0]        exe_cmd,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic              s_bit,
  input  logic              imm,
  input  logic              c_in,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] val_rn,
  input  logic [DATA_W-1:0] val_rm,
  input  logic [11:0]       shift_operand,
  input  logic [23:0]       signed_imm_24,
  input  logic [REG_AW-1:0] dest_in,
  input  logic [1:0]        sel_src1,
  input  logic [1:0]        sel_src2,
  input  logic [DATA_W-1:0] wb_result,
  output logic              busy,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] src2_out,
  output logic [REG_AW-1:0] dest_out,
  output logic [DATA_W-1:0] br_addr,
  output logic [3:0]        status,
  output logic              status_we
);

  localparam logic [3:0] OP_MOV = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_ADC = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_SBC = 4'd5;
  localparam logic [3:0] OP_AND = 4'd6;
  localparam logic [3:0] OP_ORR = 4'd7;
  localparam logic [3:0] OP_EOR = 4'd8;
  localparam logic [3:0] OP_MVN = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;

  // Rotate right; the amount wraps at the datapath width.
  function automatic logic [DATA_W-1:0] ror_f(input logic [DATA_W-1:0] x, input int amt);
    logic [2*DATA_W-1:0] dbl;
    dbl = {x, x} >> (amt % DATA_W);
    return dbl[DATA_W-1:0];
  endfunction

  // Barrel shift of the register operand; amount 0 leaves it unshifted.
  function automatic logic [DATA_W-1:0] shift_f(input logic [DATA_W-1:0] x,
                                                input logic [1:0] kind,
                                                input logic [4:0] amt);
    logic signed [DATA_W-1:0] xs;
    xs = signed'(x);
    case (kind)
      2'd0:    return x << amt;
      2'd1:    return x >> amt;
      2'd2:    return $unsigned(xs >>> amt);
      default: return ror_f(x, int'(amt));
    endcase
  endfunction

  // Second operand: load/store offset, rotated 8-bit immediate or shifted Rm.
  function automatic logic [DATA_W-1:0] val2_f(input logic [DATA_W-1:0] rm,
                                               input logic [11:0] op,
                                               input logic ld_st,
                                               input logic is_imm);
    if (ld_st)
      return DATA_W'(op);
    else if (is_imm)
      return ror_f(DATA_W'(op[7:0]), 2 * int'(op[11:8]));
    else
      return shift_f(rm, op[6:5], op[11:7]);
  endfunction

  logic              accept;
  logic              is_mul;
  logic [DATA_W-1:0] src1_p0, src2_p0, val2_p0, res_p0;
  logic [3:0]        flags_p0;
  logic              known_p0;

  logic signed [25:0]       br_off26;
  logic signed [DATA_W-1:0] br_off;

  logic              mul_done;
  logic [DATA_W-1:0] mul_res;
  logic              mul_wb;
  logic [REG_AW-1:0] mul_dest;
  logic              mul_s;
  logic              mul_c;

  assign accept = in_valid & ~freeze & ~busy;

  // ---- stage p0: forwarding, Val2, ALU (combinational) ----
  assign src1_p0 = (sel_src1 == 2'd1) ? alu_result :
                   (sel_src1 == 2'd2) ? wb_result  : val_rn;
  assign src2_p0 = (sel_src2 == 2'd1) ? alu_result :
                   (sel_src2 == 2'd2) ? wb_result  : val_rm;
  assign val2_p0 = val2_f(src2_p0, shift_operand, mem_r_en_in | mem_w_en_in, imm);

  assign br_off26 = signed'({signed_imm_24, 2'b00});
  assign br_off   = DATA_W'(br_off26);
  assign br_addr  = pc + $unsigned(br_off);

  // ALU result and NZCV flags for the instruction in the ID/EX slot.
  always_comb begin
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] opb;
    logic              arith;
    sum      = '0;
    opb      = val2_p0;
    arith    = 1'b0;
    res_p0   = '0;
    known_p0 = 1'b1;
    flags_p0 = status;
    case (exe_cmd)
      OP_ADD: begin arith = 1'b1; opb = val2_p0;  sum = {1'b0, src1_p0} + {1'b0, opb}; end
      OP_ADC: begin arith = 1'b1; opb = val2_p0;  sum = {1'b0, src1_p0} + {1'b0, opb} + (DATA_W+1)'(c_in); end
      OP_SUB: begin arith = 1'b1; opb = ~val2_p0; sum = {1'b0, src1_p0} + {1'b0, opb} + (DATA_W+1)'(1); end
      OP_SBC: begin arith = 1'b1; opb = ~val2_p0; sum = {1'b0, src1_p0} + {1'b0, opb} + (DATA_W+1)'(c_in); end
      OP_MOV: res_p0 = val2_p0;
      OP_MVN: res_p0 = ~val2_p0;
      OP_AND: res_p0 = src1_p0 & val2_p0;
      OP_ORR: res_p0 = src1_p0 | val2_p0;
      OP_EOR: res_p0 = src1_p0 ^ val2_p0;
      default: known_p0 = 1'b0;
    endcase
    if (arith) begin
      res_p0   = sum[DATA_W-1:0];
      flags_p0 = {res_p0[DATA_W-1], res_p0 == '0, sum[DATA_W],
                  (src1_p0[DATA_W-1] == opb[DATA_W-1]) && (res_p0[DATA_W-1] != src1_p0[DATA_W-1])};
    end else if (known_p0) begin
      flags_p0 = {res_p0[DATA_W-1], res_p0 == '0, c_in, 1'b0};
    end
  end

`ifdef EXE_MUL_EN
  typedef enum logic [1:0] {IDLE, MUL, DONE} mul_state_t;
  localparam int CNT_W = $clog2(DATA_W);

  mul_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] mul_acc_p1, mul_mcand_p1, mul_mplier_p1;
  logic [REG_AW-1:0] mul_dest_p1;
  logic              mul_wb_p1, mul_s_p1, mul_c_p1;

  assign is_mul   = (exe_cmd == OP_MUL);
  assign busy     = (state != IDLE);
  assign mul_done = (state == DONE);
  assign mul_res  = mul_acc_p1;
  assign mul_wb   = mul_wb_p1;
  assign mul_dest = mul_dest_p1;
  assign mul_s    = mul_s_p1;
  assign mul_c    = mul_c_p1;

  // Multiplier control FSM: one product bit per unfrozen cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mul_wb_p1 <= 1'b0;
      mul_s_p1  <= 1'b0;
    end else if (!freeze) begin
      case (state)
        IDLE: if (accept && is_mul) begin
          state     <= MUL;
          cnt       <= CNT_W'(DATA_W - 1);
          mul_wb_p1 <= wb_en_in;
          mul_s_p1  <= s_bit;
        end
        MUL: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // ---- stage p1: shift-add accumulator (data only, no reset) ----
  always_ff @(posedge clk) begin
    if (!freeze) begin
      if (state == IDLE && accept && is_mul) begin
        mul_acc_p1    <= '0;
        mul_mcand_p1  <= src1_p0;
        mul_mplier_p1 <= val2_p0;
        mul_dest_p1   <= dest_in;
        mul_c_p1      <= c_in;
      end else if (state == MUL) begin
        if (mul_mplier_p1[0]) mul_acc_p1 <= mul_acc_p1 + mul_mcand_p1;
        mul_mcand_p1  <= mul_mcand_p1 << 1;
        mul_mplier_p1 <= mul_mplier_p1 >> 1;
      end
    end
  end
`else
  assign is_mul   = 1'b0;
  assign busy     = 1'b0;
  assign mul_done = 1'b0;
  assign mul_res  = '0;
  assign mul_wb   = 1'b0;
  assign mul_dest = '0;
  assign mul_s    = 1'b0;
  assign mul_c    = 1'b0;
`endif

  // ---- stage p1: EXE/MEM output register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en      <= 1'b0;
      mem_r_en   <= 1'b0;
      mem_w_en   <= 1'b0;
      status_we  <= 1'b0;
      alu_result <= '0;
      src2_out   <= '0;
      dest_out   <= '0;
      status     <= '0;
    end else if (!freeze) begin
      if (mul_done) begin
        wb_en      <= mul_wb;
        mem_r_en   <= 1'b0;
        mem_w_en   <= 1'b0;
        status_we  <= mul_s;
        alu_result <= mul_res;
        dest_out   <= mul_dest;
        status     <= {mul_res[DATA_W-1], mul_res == '0, mul_c, 1'b0};
      end else if (accept && !is_mul) begin
        wb_en      <= wb_en_in;
        mem_r_en   <= mem_r_en_in;
        mem_w_en   <= mem_w_en_in;
        status_we  <= s_bit & known_p0;
        alu_result <= res_p0;
        src2_out   <= src2_p0;
        dest_out   <= dest_in;
        status     <= flags_p0;
      end else begin
        wb_en     <= 1'b0;
        mem_r_en  <= 1'b0;
        mem_w_en  <= 1'b0;
        status_we <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_exe_stage_mc.sv
// tb_exe_stage_mc: directed self-checking bench for exe_stage_mc (DATA_W=32).
// Multiplier scenarios are compiled in when EXE_MUL_EN is defined.
module tb_exe_stage_mc;
  logic        clk = 1'b0;
  logic        rst, freeze, in_valid;
  logic [3:0]  exe_cmd;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in, s_bit, imm, c_in;
  logic [31:0] pc, val_rn, val_rm, wb_result;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm_24;
  logic [3:0]  dest_in;
  logic [1:0]  sel_src1, sel_src2;
  logic        busy, wb_en, mem_r_en, mem_w_en, status_we;
  logic [31:0] alu_result, src2_out, br_addr;
  logic [3:0]  dest_out, status;

  int errors = 0;
  int checks = 0;

  exe_stage_mc #(.DATA_W(32), .REG_AW(4)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .in_valid(in_valid), .exe_cmd(exe_cmd),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .s_bit(s_bit), .imm(imm), .c_in(c_in), .pc(pc), .val_rn(val_rn), .val_rm(val_rm),
    .shift_operand(shift_operand), .signed_imm_24(signed_imm_24), .dest_in(dest_in),
    .sel_src1(sel_src1), .sel_src2(sel_src2), .wb_result(wb_result),
    .busy(busy), .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .alu_result(alu_result), .src2_out(src2_out), .dest_out(dest_out),
    .br_addr(br_addr), .status(status), .status_we(status_we)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                        input logic [11:0] op, input logic s, input logic im);
    in_valid = 1'b1; exe_cmd = cmd; val_rn = rn; val_rm = rm;
    shift_operand = op; s_bit = s; imm = im; wb_en_in = 1'b1;
    mem_r_en_in = 1'b0; mem_w_en_in = 1'b0; sel_src1 = 2'd0; sel_src2 = 2'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; freeze = 1'b0; c_in = 1'b0; pc = '0; wb_result = '0;
    signed_imm_24 = '0; dest_in = 4'd3;
    set_op(4'd2, 32'd5, 32'd3, 12'h000, 1'b1, 1'b0);
    tick(); tick();
    checks++; if (alu_result !== 32'd0) begin errors++; $display("FAIL reset_alu got=%h exp=0", alu_result); end
    checks++; if ({wb_en, mem_r_en, mem_w_en, status_we, busy} !== 5'b0) begin errors++; $display("FAIL reset_ctrl got=%b exp=00000", {wb_en, mem_r_en, mem_w_en, status_we, busy}); end
    checks++; if ({status, dest_out} !== 8'h00) begin errors++; $display("FAIL reset_status got=%h exp=00", {status, dest_out}); end
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_add_sub();
    set_op(4'd2, 32'd5, 32'd3, 12'h000, 1'b1, 1'b0); dest_in = 4'd7;
    tick();
    checks++; if (alu_result !== 32'd8) begin errors++; $display("FAIL add_result got=%h exp=8", alu_result); end
    checks++; if ({status, status_we, wb_en, dest_out} !== {4'b0000, 1'b1, 1'b1, 4'd7}) begin errors++; $display("FAIL add_ctrl got=%b exp=0000_1_1_0111", {status, status_we, wb_en, dest_out}); end
    set_op(4'd4, 32'd3, 32'd5, 12'h000, 1'b1, 1'b0);
    tick();
    checks++; if ({alu_result, status} !== {32'hFFFFFFFE, 4'b1000}) begin errors++; $display("FAIL sub_neg got=%h/%b exp=fffffffe/1000", alu_result, status); end
    set_op(4'd4, 32'd5, 32'd5, 12'h000, 1'b1, 1'b0);
    tick();
    checks++; if ({alu_result, status} !== {32'h0, 4'b0110}) begin errors++; $display("FAIL sub_zero got=%h/%b exp=0/0110", alu_result, status); end
    set_op(4'd2, 32'h7FFFFFFF, 32'd1, 12'h000, 1'b1, 1'b0);
    tick();
    checks++; if ({alu_result, status} !== {32'h80000000, 4'b1001}) begin errors++; $display("FAIL add_ovf got=%h/%b exp=80000000/1001", alu_result, status); end
  endtask

  task automatic test_carry_ops();
    c_in = 1'b1;
    set_op(4'd3, 32'hFFFFFFFF, 32'd0, 12'h000, 1'b1, 1'b0);
    tick();
    checks++; if ({alu_result, status} !== {32'h0, 4'b0110}) begin errors++; $display("FAIL adc got=%h/%b exp=0/0110", alu_result, status); end
    c_in = 1'b0;
    set_op(4'd5, 32'd5, 32'd3, 12'h000, 1'b1, 1'b0);
    tick();
    checks++; if ({alu_result, status} !== {32'd1, 4'b0010}) begin errors++; $display("FAIL sbc got=%h/%b exp=1/0010", alu_result, status); end
  endtask

  task automatic test_logic();
    c_in = 1'b1;
    set_op(4'd6, 32'hF0, 32'h3C, 12'h000, 1'b1, 1'b0);
    tick();
    checks++; if ({alu_result, status} !== {32'h30, 4'b0010}) begin errors++; $display("FAIL and got=%h/%b exp=30/0010", alu_result, status); end
    set_op(4'd7, 32'hF0, 32'h0F, 12'h000, 1'b0, 1'b0);
    tick();
    checks++; if ({alu_result, status_we} !== {32'hFF, 1'b0}) begin errors++; $display("FAIL orr got=%h/%b exp=ff/0", alu_result, status_we); end
    set_op(4'd8, 32'hFF, 32'h0F, 12'h000, 1'b1, 1'b0);
    tick();
    checks++; if (alu_result !== 32'hF0) begin errors++; $display("FAIL eor got=%h exp=f0", alu_result); end
    c_in = 1'b0;
    set_op(4'd9, 32'd0, 32'd0, 12'h000, 1'b1, 1'b0);
    tick();
    checks++; if ({alu_result, status} !== {32'hFFFFFFFF, 4'b1000}) begin errors++; $display("FAIL mvn got=%h/%b exp=ffffffff/1000", alu_result, status); end
  endtask

  task automatic test_val2();
    set_op(4'd1, 32'd0, 32'd0, 12'h4FF, 1'b0, 1'b1);
    tick();
    checks++; if (alu_result !== 32'hFF000000) begin errors++; $display("FAIL imm_rot got=%h exp=ff000000", alu_result); end
    set_op(4'd2, 32'h100, 32'h55, 12'h004, 1'b0, 1'b0); mem_r_en_in = 1'b1;
    tick();
    checks++; if ({alu_result, mem_r_en, src2_out} !== {32'h104, 1'b1, 32'h55}) begin errors++; $display("FAIL ldr got=%h/%b/%h exp=104/1/55", alu_result, mem_r_en, src2_out); end
    set_op(4'd1, 32'd0, 32'd1, 12'h200, 1'b0, 1'b0);
    tick();
    checks++; if (alu_result !== 32'h10) begin errors++; $display("FAIL lsl got=%h exp=10", alu_result); end
    set_op(4'd1, 32'd0, 32'h80, 12'h220, 1'b0, 1'b0);
    tick();
    checks++; if (alu_result !== 32'h8) begin errors++; $display("FAIL lsr got=%h exp=8", alu_result); end
    set_op(4'd1, 32'd0, 32'h80000000, 12'h240, 1'b0, 1'b0);
    tick();
    checks++; if (alu_result !== 32'hF8000000) begin errors++; $display("FAIL asr got=%h exp=f8000000", alu_result); end
    set_op(4'd1, 32'd0, 32'hF, 12'h260, 1'b0, 1'b0);
    tick();
    checks++; if (alu_result !== 32'hF0000000) begin errors++; $display("FAIL ror got=%h exp=f0000000", alu_result); end
    pc = 32'h100; signed_imm_24 = 24'hFFFFFE;
    #1;
    checks++; if (br_addr !== 32'hF8) begin errors++; $display("FAIL br_back got=%h exp=f8", br_addr); end
    signed_imm_24 = 24'h000010;
    #1;
    checks++; if (br_addr !== 32'h140) begin errors++; $display("FAIL br_fwd got=%h exp=140", br_addr); end
  endtask

  task automatic test_back_to_back();
    set_op(4'd2, 32'd5, 32'd3, 12'h000, 1'b1, 1'b0);
    tick();
    set_op(4'd2, 32'd999, 32'd1, 12'h000, 1'b1, 1'b0); sel_src1 = 2'd1;
    tick();
    checks++; if (alu_result !== 32'd9) begin errors++; $display("FAIL fwd_alu got=%h exp=9", alu_result); end
    set_op(4'd2, 32'd1, 32'd999, 12'h000, 1'b1, 1'b0); sel_src2 = 2'd2; wb_result = 32'h20;
    tick();
    checks++; if ({alu_result, src2_out} !== {32'h21, 32'h20}) begin errors++; $display("FAIL fwd_wb got=%h/%h exp=21/20", alu_result, src2_out); end
    set_op(4'd2, 32'd2, 32'd2, 12'h000, 1'b1, 1'b0); sel_src1 = 2'd3;
    tick();
    checks++; if (alu_result !== 32'd4) begin errors++; $display("FAIL fwd_sel3 got=%h exp=4", alu_result); end
  endtask

  task automatic test_bubble_freeze_unknown();
    set_op(4'd2, 32'd5, 32'd3, 12'h000, 1'b1, 1'b0);
    tick();
    freeze = 1'b1; set_op(4'd4, 32'd1, 32'd1, 12'h000, 1'b0, 1'b0); wb_en_in = 1'b0;
    tick(); tick();
    checks++; if ({alu_result, status_we, wb_en} !== {32'd8, 1'b1, 1'b1}) begin errors++; $display("FAIL freeze_hold got=%h/%b/%b exp=8/1/1", alu_result, status_we, wb_en); end
    freeze = 1'b0; in_valid = 1'b0;
    tick();
    checks++; if ({wb_en, mem_r_en, mem_w_en, status_we} !== 4'b0000) begin errors++; $display("FAIL bubble got=%b exp=0000", {wb_en, mem_r_en, mem_w_en, status_we}); end
    set_op(4'd0, 32'd5, 32'd3, 12'h000, 1'b1, 1'b0); mem_w_en_in = 1'b1;
    tick();
    checks++; if ({alu_result, status_we, wb_en, mem_w_en} !== {32'd0, 1'b0, 1'b1, 1'b1}) begin errors++; $display("FAIL unknown_op got=%h/%b/%b/%b exp=0/0/1/1", alu_result, status_we, wb_en, mem_w_en); end
`ifndef EXE_MUL_EN
    set_op(4'd10, 32'd7, 32'd6, 12'h000, 1'b1, 1'b0);
    tick();
    checks++; if ({alu_result, status_we, wb_en, busy} !== {32'd0, 1'b0, 1'b1, 1'b0}) begin errors++; $display("FAIL mul_disabled got=%h/%b/%b/%b exp=0/0/1/0", alu_result, status_we, wb_en, busy); end
`endif
    in_valid = 1'b0;
    tick();
  endtask

`ifdef EXE_MUL_EN
  task automatic test_mul(input int freeze_at);
    int n;
    c_in = 1'b1; dest_in = 4'd9;
    set_op(4'd10, 32'd7, 32'd6, 12'h000, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      n++;
      checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL mul_bubble n=%0d got=%b exp=0", n, wb_en); end
      if (freeze_at > 0 && n == freeze_at) freeze = 1'b1;
      if (freeze_at > 0 && n == freeze_at + 5) freeze = 1'b0;
      tick();
    end
    checks++; if (n !== ((freeze_at > 0) ? 38 : 33)) begin errors++; $display("FAIL mul_busy_len got=%0d exp=%0d", n, (freeze_at > 0) ? 38 : 33); end
    checks++; if ({alu_result, wb_en, dest_out, status, status_we} !== {32'd42, 1'b1, 4'd9, 4'b0010, 1'b1}) begin errors++; $display("FAIL mul_result got=%h/%b/%h/%b/%b exp=2a/1/9/0010/1", alu_result, wb_en, dest_out, status, status_we); end
    c_in = 1'b0;
    tick();
  endtask

  task automatic test_mul_reset();
    set_op(4'd10, 32'd7, 32'd6, 12'h000, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mul_mid_busy got=%b exp=1", busy); end
    rst = 1'b1;
    tick();
    checks++; if ({busy, wb_en, status_we, alu_result} !== {3'b000, 32'd0}) begin errors++; $display("FAIL mul_abort got=%b/%h exp=000/0", {busy, wb_en, status_we}, alu_result); end
    rst = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_add_sub();
    test_carry_ops();
    test_logic();
    test_val2();
    test_back_to_back();
    test_bubble_freeze_unknown();
`ifdef EXE_MUL_EN
    test_mul(0);
    test_mul(10);
    test_mul_reset();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
